// File: rtl/mrv32_lsu.sv
// mrv32_lsu: turns one execute-stage load/store into a word-aligned data-bus
// transaction with byte strobes and returns extended load data or an error.
module mrv32_lsu #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned STRB = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Timeout fires at the end of the last allowed REQ/WAIT cycle.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           ofs_q, ofs_d;
  logic [2:0]           f3_q, f3_d;
  logic                 load_q, load_d;

  logic                 req_ready_q, req_ready_d;
  logic                 dmem_valid_q, dmem_valid_d;
  logic [XLEN-1:0]      dmem_addr_q, dmem_addr_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [STRB-1:0]      dmem_wstrb_q, dmem_wstrb_d;
  logic [XLEN-1:0]      dmem_wdata_q, dmem_wdata_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [XLEN-1:0]      resp_rdata_q, resp_rdata_d;

  logic                 req_load;
  logic                 req_illegal;
  logic                 req_misaligned;
  logic [STRB-1:0]      fmt_wstrb;
  logic [XLEN-1:0]      fmt_wdata;
  logic                 tmo_hit;

  // Pick the addressed byte/halfword lane and extend it according to funct3.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      ofs,
                                                   input logic [2:0]      f3);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = word[{ofs, 3'b000} +: 8];
    lane_h = word[{ofs[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    return {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_BU:   return {{(XLEN-8){1'b0}}, lane_b};
      F3_H:    return {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_HU:   return {{(XLEN-16){1'b0}}, lane_h};
      default: return word;
    endcase
  endfunction

  // Request legality, alignment and store lane formatting, decoded straight off the inputs.
  always_comb begin
    req_load    = req_ren & ~req_wen;
    req_illegal = (req_ren == req_wen);
    if (req_ren && ((req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111))) begin
      req_illegal = 1'b1;
    end
    if (req_wen && (req_f3 != F3_B) && (req_f3 != F3_H) && (req_f3 != F3_W)) begin
      req_illegal = 1'b1;
    end
    req_misaligned = ((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fmt_wstrb = '0;
    fmt_wdata = '0;
    if (req_wen) begin
      case (req_f3[1:0])
        2'b00: begin
          fmt_wstrb = STRB'(4'b0001 << req_addr[1:0]);
          fmt_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          fmt_wstrb = STRB'(4'b0011 << {req_addr[1], 1'b0});
          fmt_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          fmt_wstrb = 4'b1111;
          fmt_wdata = req_wdata;
        end
      endcase
    end
  end

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ofs_d        = ofs_q;
    f3_d         = f3_q;
    load_d       = load_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_wstrb_d = dmem_wstrb_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ofs_d        = req_addr[1:0];
          f3_d         = req_f3;
          load_d       = req_load;
          cnt_d        = '0;
          dmem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
          dmem_we_d    = req_wen;
          dmem_wstrb_d = fmt_wstrb;
          dmem_wdata_d = fmt_wdata;
          if (req_illegal || req_misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (dmem_ready) begin
          if (!load_q) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = dmem_err;
          end else if (dmem_rvalid) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = dmem_err;
            resp_rdata_d = dmem_err ? '0 : load_extract(dmem_rdata, ofs_q, f3_q);
          end else begin
            state_d = S_WAIT;
          end
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (dmem_rvalid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = dmem_err;
          resp_rdata_d = dmem_err ? '0 : load_extract(dmem_rdata, ofs_q, f3_q);
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dmem_valid_d = (state_d == S_REQ);
    req_ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ofs_q        <= '0;
      f3_q         <= '0;
      load_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      dmem_valid_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wstrb_q <= '0;
      dmem_wdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ofs_q        <= ofs_d;
      f3_q         <= f3_d;
      load_q       <= load_d;
      req_ready_q  <= req_ready_d;
      dmem_valid_q <= dmem_valid_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_we_q    <= dmem_we_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      dmem_wdata_q <= dmem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = (state_q != S_IDLE) | (req_valid & (state_q == S_IDLE));
  assign dmem_valid = dmem_valid_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign dmem_wdata = dmem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mrv32_lsu.sv
// tb_mrv32_lsu: directed and randomized transactions checked cycle by cycle
// against a transaction-level model of the load/store unit.
module tb_mrv32_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_ren = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        dmem_valid;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_err = 1'b0;

  int checks = 0;
  int errors = 0;

  int          lat, rcnt, dvc;
  logic [31:0] ord, oad, owd;
  logic        oer, owe;
  logic [3:0]  ows;

  mrv32_lsu #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ren(req_ren), .req_wen(req_wen),
    .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One transaction from an idle negedge: r = cycle of dmem_ready, v = cycle of
  // dmem_rvalid (0 = never). Expected behaviour comes from the transaction model.
  task automatic do_txn(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int r, input int v, input logic [31:0] word, input logic e,
                        output int o_lat, output int o_rcnt, output int o_dvc,
                        output logic [31:0] o_rdata, output logic o_err,
                        output logic [31:0] o_addr, output logic [3:0] o_wstrb,
                        output logic [31:0] o_wdata, output logic o_we);
    bit ld, bad, bus_done;
    int sz, a, c, dv_end, kmax;
    logic [31:0] bb, hh, ext, x_rdata, x_wdata, x_addr;
    logic [3:0]  x_wstrb;
    logic        x_err, x_rv, x_dv, x_rdy, x_busy;

    ld  = ren && !wen;
    bad = (ren == wen);
    if (!bad && ld)  bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (!bad && !ld) bad = (f3 > 3'd2);
    sz = int'(f3) % 4;
    a  = int'(addr % 32'd4);
    if (!bad && sz == 1 && (a % 2) != 0) bad = 1;
    if (!bad && sz == 2 && a != 0) bad = 1;

    bb = (word >> (8 * a)) & 32'hFF;
    hh = (word >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    ext = (bb >= 32'd128) ? bb - 32'd256 : bb;
      3'd4:    ext = bb;
      3'd1:    ext = (hh >= 32'd32768) ? hh - 32'd65536 : hh;
      3'd5:    ext = hh;
      default: ext = word;
    endcase
    x_addr  = addr - 32'(a);
    x_wstrb = 4'd0;
    x_wdata = 32'd0;
    if (!ld) begin
      if (sz == 0)      begin x_wstrb = 4'(1 << a); x_wdata = (wdata & 32'hFF) * 32'h01010101; end
      else if (sz == 1) begin x_wstrb = 4'(3 << a); x_wdata = (wdata & 32'hFFFF) * 32'h00010001; end
      else              begin x_wstrb = 4'hF;       x_wdata = wdata; end
    end

    bus_done = (r >= 1) && (r <= TMO);
    dv_end   = bad ? 0 : (bus_done ? r : TMO);
    if (bad)                                       begin c = 0;   x_err = 1'b1; x_rdata = 32'd0; end
    else if (ld && bus_done && v >= r && v <= TMO) begin c = v;   x_err = e;    x_rdata = e ? 32'd0 : ext; end
    else if (!ld && bus_done)                      begin c = r;   x_err = e;    x_rdata = 32'd0; end
    else                                           begin c = TMO; x_err = 1'b1; x_rdata = 32'd0; end
    kmax = c + 2;
    if (r + 1 > kmax) kmax = r + 1;
    if (v + 1 > kmax) kmax = v + 1;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; req_ren = ren; req_wen = wen; req_f3 = f3;
    req_addr = addr; req_wdata = wdata;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL accept_busy got=%b exp=1", busy);
    end
    o_lat = 0; o_rcnt = 0; o_dvc = 0; o_rdata = 32'd0; o_err = 1'b0;
    o_addr = 32'd0; o_wstrb = 4'd0; o_wdata = 32'd0; o_we = 1'b0;

    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      x_rv   = (k == c + 1);
      x_dv   = (k <= dv_end);
      x_rdy  = (k >= c + 2);
      x_busy = (k <= c + 1);
      if (resp_valid === 1'b1) begin
        o_rcnt++;
        if (o_lat == 0) begin o_lat = k; o_rdata = resp_rdata; o_err = resp_err; end
      end
      if (dmem_valid === 1'b1) begin
        o_dvc++;
        if (o_dvc == 1) begin o_addr = dmem_addr; o_wstrb = dmem_wstrb; o_wdata = dmem_wdata; o_we = dmem_we; end
      end
      checks++;
      if (resp_valid !== x_rv) begin
        errors++; $display("FAIL resp_valid cyc=%0d got=%b exp=%b", k, resp_valid, x_rv);
      end
      if (x_rv) begin
        checks++;
        if (resp_err !== x_err || resp_rdata !== x_rdata) begin
          errors++; $display("FAIL resp_data cyc=%0d got err=%b rdata=%h exp err=%b rdata=%h",
                             k, resp_err, resp_rdata, x_err, x_rdata);
        end
      end
      checks++;
      if (dmem_valid !== x_dv) begin
        errors++; $display("FAIL dmem_valid cyc=%0d got=%b exp=%b", k, dmem_valid, x_dv);
      end
      if (x_dv) begin
        checks++;
        if (dmem_addr !== x_addr || dmem_we !== !ld || dmem_wstrb !== x_wstrb ||
            (!ld && dmem_wdata !== x_wdata)) begin
          errors++; $display("FAIL dmem_fields cyc=%0d got addr=%h we=%b strb=%b wdata=%h exp addr=%h we=%b strb=%b wdata=%h",
                             k, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, x_addr, !ld, x_wstrb, x_wdata);
        end
      end
      checks++;
      if (req_ready !== x_rdy || busy !== x_busy) begin
        errors++; $display("FAIL ready_busy cyc=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                           k, req_ready, busy, x_rdy, x_busy);
      end
      // Requests while busy carry junk and must be ignored.
      req_valid = (k <= c);
      req_ren   = 1'($urandom);
      req_wen   = 1'($urandom);
      req_f3    = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      dmem_ready  = (k == r);
      dmem_rvalid = (k == v);
      dmem_err    = ((ld && k == v) || (!ld && k == r)) ? e : 1'($urandom);
      dmem_rdata  = (k == v) ? word : $urandom;
    end
    req_valid = 1'b0;
    dmem_err  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, busy, resp_valid, resp_err, dmem_valid, dmem_we, dmem_wstrb} !== 10'b1000000000 ||
        resp_rdata !== 32'd0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got ready=%b busy=%b rv=%b dv=%b addr=%h exp ready=1 others=0",
                         req_ready, busy, resp_valid, dmem_valid, dmem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%b busy=%b rv=%b exp 1/0/0", req_ready, busy, resp_valid);
    end
  endtask

  task automatic test_store_sb();
    do_txn(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 1, 0, 32'd0, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (oad !== 32'h1000 || ows !== 4'b1000 || owd !== 32'hDDDDDDDD || owe !== 1'b1) begin
      errors++; $display("FAIL sb_bus got addr=%h strb=%b wdata=%h we=%b exp 00001000/1000/dddddddd/1",
                         oad, ows, owd, owe);
    end
    checks++;
    if (lat !== 2 || oer !== 1'b0) begin
      errors++; $display("FAIL sb_resp got lat=%0d err=%b exp lat=2 err=0", lat, oer);
    end
  endtask

  task automatic test_loads();
    do_txn(1'b1, 1'b0, 3'b000, 32'h2001, 32'd0, 1, 4, 32'h1234F0AA, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (ord !== 32'hFFFFFFF0 || lat !== 5 || oer !== 1'b0) begin
      errors++; $display("FAIL lb got rdata=%h lat=%0d err=%b exp fffffff0/5/0", ord, lat, oer);
    end
    do_txn(1'b1, 1'b0, 3'b100, 32'h2001, 32'd0, 1, 4, 32'h1234F0AA, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (ord !== 32'h000000F0) begin
      errors++; $display("FAIL lbu got rdata=%h exp 000000f0", ord);
    end
    do_txn(1'b1, 1'b0, 3'b001, 32'h2002, 32'd0, 1, 4, 32'h1234F0AA, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (ord !== 32'h00001234 || oad !== 32'h2000 || ows !== 4'b0000) begin
      errors++; $display("FAIL lh got rdata=%h addr=%h strb=%b exp 00001234/00002000/0000", ord, oad, ows);
    end
    do_txn(1'b1, 1'b0, 3'b010, 32'h2004, 32'd0, 1, 1, 32'h8765ABCD, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (ord !== 32'h8765ABCD || lat !== 2) begin
      errors++; $display("FAIL lw_same_cycle got rdata=%h lat=%0d exp 8765abcd/2", ord, lat);
    end
  endtask

  task automatic test_misaligned();
    do_txn(1'b1, 1'b0, 3'b010, 32'h3002, 32'd0, 1, 1, 32'hFFFFFFFF, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (lat !== 1 || oer !== 1'b1 || dvc !== 0 || ord !== 32'd0) begin
      errors++; $display("FAIL lw_misaligned got lat=%0d err=%b dv=%0d rdata=%h exp 1/1/0/0", lat, oer, dvc, ord);
    end
    do_txn(1'b0, 1'b1, 3'b001, 32'h3001, 32'h12345678, 1, 0, 32'd0, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (lat !== 1 || oer !== 1'b1 || dvc !== 0) begin
      errors++; $display("FAIL sh_misaligned got lat=%0d err=%b dv=%0d exp 1/1/0", lat, oer, dvc);
    end
    do_txn(1'b1, 1'b1, 3'b010, 32'h3000, 32'd0, 1, 0, 32'd0, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (lat !== 1 || oer !== 1'b1 || dvc !== 0) begin
      errors++; $display("FAIL ren_wen_both got lat=%0d err=%b dv=%0d exp 1/1/0", lat, oer, dvc);
    end
    do_txn(1'b1, 1'b0, 3'b011, 32'h3000, 32'd0, 1, 1, 32'd0, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (lat !== 1 || oer !== 1'b1 || dvc !== 0) begin
      errors++; $display("FAIL load_f3_011 got lat=%0d err=%b dv=%0d exp 1/1/0", lat, oer, dvc);
    end
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 1'b1, 3'b010, 32'h4000, 32'hCAFEF00D, 0, 7, 32'h0, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (dvc !== TMO || lat !== TMO + 1 || oer !== 1'b1 || rcnt !== 1) begin
      errors++; $display("FAIL sw_timeout got dv=%0d lat=%0d err=%b resps=%0d exp 4/5/1/1", dvc, lat, oer, rcnt);
    end
    do_txn(1'b1, 1'b0, 3'b010, 32'h4004, 32'd0, 1, 6, 32'h11112222, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (lat !== TMO + 1 || oer !== 1'b1 || ord !== 32'd0 || rcnt !== 1) begin
      errors++; $display("FAIL lw_wait_timeout got lat=%0d err=%b rdata=%h resps=%0d exp 5/1/0/1", lat, oer, ord, rcnt);
    end
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 1'b1, 3'b010, 32'h5000, 32'h0BADBEEF, 2, 0, 32'd0, 1'b0,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (oer !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL b2b_sw got err=%b lat=%0d exp 0/3", oer, lat);
    end
    do_txn(1'b1, 1'b0, 3'b010, 32'h5004, 32'd0, 1, 2, 32'h76543210, 1'b1,
           lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    checks++;
    if (oer !== 1'b1 || ord !== 32'd0 || lat !== 3) begin
      errors++; $display("FAIL b2b_lw_err got err=%b rdata=%h lat=%0d exp 1/0/3", oer, ord, lat);
    end
  endtask

  task automatic test_async_reset();
    for (int p = 0; p < 2; p++) begin
      req_valid = 1'b1; req_ren = 1'b1; req_wen = 1'b0; req_f3 = 3'b010;
      req_addr = 32'h6000; req_wdata = 32'd0;
      @(negedge clk);
      req_valid = 1'b0;
      if (p == 1) begin
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
      end
      checks++;
      if (req_ready !== 1'b0 || dmem_valid !== (p == 0)) begin
        errors++; $display("FAIL rst_pre phase=%0d got ready=%b dv=%b", p, req_ready, dmem_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, busy, resp_valid, resp_err, dmem_valid, dmem_we, dmem_wstrb} !== 10'b1000000000 ||
          resp_rdata !== 32'd0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
        errors++; $display("FAIL rst_async phase=%0d got ready=%b busy=%b rv=%b dv=%b addr=%h exp ready=1 others=0",
                           p, req_ready, busy, resp_valid, dmem_valid, dmem_addr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h55AA55AA;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++; $display("FAIL rst_after phase=%0d cyc=%0d got rv=%b ready=%b exp 0/1", p, k, resp_valid, req_ready);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ren, wen, e;
    logic [2:0] f3;
    logic [31:0] addr, wdata, word;
    int r, v, sel;
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin ren = 1'($urandom); wen = ren; end
      else begin ren = 1'(sel % 2); wen = !ren; end
      if (sel >= 17) f3 = 3'($urandom);
      else if (ren) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      r = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(1, 3));
      if (ren && !wen) begin
        if (r <= TMO) v = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(r, 6));
        else          v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 7));
      end else v = int'($urandom_range(0, 7));
      wdata = $urandom;
      word  = $urandom;
      e     = ($urandom_range(0, 5) == 0);
      do_txn(ren, wen, f3, addr, wdata, r, v, word, e,
             lat, rcnt, dvc, ord, oer, oad, ows, owd, owe);
    end
  endtask

  initial begin
    test_reset();
    test_store_sb();
    test_loads();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
